// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: load/store funct3 encodings, the subset of
// the control word consumed by the MEM stage, and the data-memory FSM states.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } rv32i_control_word;

endpackage

// File: rtl/mem_stage_dmem_load_align.sv
// Load formatter: picks the byte/half addressed by addr_lo out of the memory
// word and sign- or zero-extends it. Purely combinational so the writeback
// forwarding path can reuse it. Halfwords select on addr_lo[1] only; words
// ignore addr_lo entirely.
module mem_stage_dmem_load_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data_out
);

  logic [7:0]         byte_u;
  logic [15:0]        half_u;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Lane select and extension
  always_comb begin
    byte_u   = rdata[{addr_lo, 3'b000} +: 8];
    half_u   = rdata[{addr_lo[1], 4'b0000} +: 16];
    byte_s   = $signed(byte_u);
    half_s   = $signed(half_u);
    data_out = rdata;
    case (funct3)
      LB:      data_out = 32'(byte_s);
      LBU:     data_out = {24'h0, byte_u};
      LH:      data_out = 32'(half_s);
      LHU:     data_out = {16'h0, half_u};
      LW:      data_out = rdata;
      default: data_out = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data-memory access unit. Issues one load/store per held
// instruction, stalls upstream until the memory answers (or the watchdog
// fires), and presents the formatted load result to MEM/WB.
// Optional build macro: DMEM_MISALIGN_CHECK_EN -- when defined, misaligned
// word/halfword accesses are suppressed and flagged on misalign_err.
module mem_stage_dmem
  import rv32i_types::*;
#(
  parameter int unsigned RESP_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       write_data_in,
  input  logic [3:0]        mem_byte_enable,
  input  logic              advance_in,
  output logic [31:0]       dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              stall_out,
  output logic [31:0]       load_data_out,
  output logic              misalign_err,
  output logic              timeout_err
);

  dmem_state_t state, next_state;

  logic        access;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic        issue;
  logic        req_active;
  logic        timeout_hit;
  logic [31:0] wait_cnt;
  logic [31:0] store_lane;
  logic [31:0] aligned_rdata;

  // Both mem_read and mem_write set is illegal and is handled as a load.
  assign access   = ctrl_word_in.mem_read | ctrl_word_in.mem_write;
  assign is_load  = ctrl_word_in.mem_read;
  assign is_store = ctrl_word_in.mem_write & ~ctrl_word_in.mem_read;

`ifdef DMEM_MISALIGN_CHECK_EN
  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  always_comb begin
    misaligned = 1'b0;
    if (access) begin
      if (ctrl_word_in.funct3[1:0] == 2'b10)
        misaligned = (addr_in[1:0] != 2'b00);
      else if (ctrl_word_in.funct3[1:0] == 2'b01)
        misaligned = addr_in[0];
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign issue       = (state == IDLE) && access && !misaligned;
  assign req_active  = issue || (state == WAIT);
  assign timeout_hit = (RESP_TIMEOUT != 0) && (state == WAIT) && !dmem_resp &&
                       (wait_cnt == RESP_TIMEOUT - 1);

  assign dmem_address = {addr_in[31:2], 2'b00};

  // Store data moved onto the byte lanes selected by the address.
  always_comb begin
    store_lane = write_data_in;
    case (ctrl_word_in.funct3)
      SB:      store_lane = {24'h0, write_data_in[7:0]} << {addr_in[1:0], 3'b000};
      SH:      store_lane = {16'h0, write_data_in[15:0]} << {addr_in[1], 4'b0000};
      SW:      store_lane = write_data_in;
      default: store_lane = write_data_in;
    endcase
  end

  mem_stage_dmem_load_align u_load_align (
    .funct3   (ctrl_word_in.funct3),
    .addr_lo  (addr_in[1:0]),
    .rdata    (dmem_rdata),
    .data_out (aligned_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next-state logic; responses outside WAIT are ignored
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (access) next_state = misaligned ? DONE : WAIT;
      WAIT: if (dmem_resp || timeout_hit) next_state = DONE;
      DONE: if (advance_in) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: request live in the issuing IDLE cycle and throughout WAIT
  always_comb begin
    stall_out  = ((state == IDLE) && access) || (state == WAIT);
    dmem_read  = req_active && is_load;
    dmem_write = req_active && is_store;
    dmem_wmask = (req_active && is_store) ? mem_byte_enable : 4'h0;
    dmem_wdata = (req_active && is_store) ? store_lane : 32'h0;
  end

  // Watchdog counter, load result and timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt      <= 32'h0;
      load_data_out <= 32'h0;
      timeout_err   <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state == IDLE)
        wait_cnt <= 32'h0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 32'd1;
      if ((state == WAIT) && dmem_resp && is_load)
        load_data_out <= aligned_rdata;
      else if (timeout_hit)
        load_data_out <= 32'h0;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  // Misalignment flag: raised on the skip to DONE, held until DONE is left
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_err <= 1'b0;
    else if ((state == IDLE) && access && misaligned)
      misalign_err <= 1'b1;
    else if ((state == DONE) && advance_in)
      misalign_err <= 1'b0;
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for mem_stage_dmem with a short watchdog (RESP_TIMEOUT=8).
module tb_mem_stage_dmem;
  import rv32i_types::*;

  logic              clk;
  logic              rst;
  rv32i_control_word ctrl;
  logic [31:0]       addr_in;
  logic [31:0]       write_data_in;
  logic [3:0]        mem_byte_enable;
  logic              advance_in;
  logic [31:0]       dmem_address;
  logic              dmem_read;
  logic              dmem_write;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              stall_out;
  logic [31:0]       load_data_out;
  logic              misalign_err;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wmask;
  int          stalls;
  int          reqs;

  mem_stage_dmem #(.RESP_TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .ctrl_word_in    (ctrl),
    .addr_in         (addr_in),
    .write_data_in   (write_data_in),
    .mem_byte_enable (mem_byte_enable),
    .advance_in      (advance_in),
    .dmem_address    (dmem_address),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .dmem_wmask      (dmem_wmask),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_resp       (dmem_resp),
    .stall_out       (stall_out),
    .load_data_out   (load_data_out),
    .misalign_err    (misalign_err),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    ctrl.mem_read   = rd;
    ctrl.mem_write  = wr;
    ctrl.funct3     = f3;
    addr_in         = addr;
    write_data_in   = wd;
    mem_byte_enable = be;
  endtask

  // Present an access, answer it in WAIT cycle 'delay', return in DONE.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] rdata, input int delay);
    drive(rd, wr, f3, addr, wd, be);
    stalls = 0;
    reqs   = 0;
    #1;
    cap_addr  = dmem_address;
    cap_wdata = dmem_wdata;
    cap_wmask = dmem_wmask;
    if (stall_out) stalls++;
    if (dmem_read || dmem_write) reqs++;
    tick();
    for (int i = 1; i <= delay; i++) begin
      if (i == delay) begin
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      if (stall_out) stalls++;
      if (dmem_read || dmem_write) reqs++;
      tick();
      dmem_resp = 1'b0;
    end
  endtask

  task automatic retire();
    advance_in = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 4'h0);
    tick();
    advance_in = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    advance_in = 1'b0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 4'h0);
    #2;
    chk1("rst_stall", stall_out, 1'b0);
    chk1("rst_read", dmem_read, 1'b0);
    chk1("rst_write", dmem_write, 1'b0);
    chk("rst_wmask", {28'h0, dmem_wmask}, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_load", load_data_out, 32'h0);
    chk1("rst_misalign", misalign_err, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // lw @0x100, response in the third WAIT cycle
    do_access(1'b1, 1'b0, LW, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 3);
    chk("lw_stalls", 32'(stalls), 32'd4);
    chk("lw_req_cycles", 32'(reqs), 32'd4);
    chk("lw_addr", cap_addr, 32'h100);
    #1;
    chk("lw_load", load_data_out, 32'hDEADBEEF);
    chk1("lw_done_stall", stall_out, 1'b0);
    chk1("lw_done_read", dmem_read, 1'b0);
    retire();

    // lb / lbu at byte 3 of 0x80FF0000, fastest response
    do_access(1'b1, 1'b0, LB, 32'h103, 32'h0, 4'h0, 32'h80FF0000, 1);
    chk("lb_stalls", 32'(stalls), 32'd2);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_load", load_data_out, 32'hFFFFFF80);
    retire();
    do_access(1'b1, 1'b0, LBU, 32'h103, 32'h0, 4'h0, 32'h80FF0000, 1);
    chk("lbu_load", load_data_out, 32'h00000080);
    retire();

    // halfword loads: upper half signed, lower half unsigned
    do_access(1'b1, 1'b0, LH, 32'h102, 32'h0, 4'h0, 32'h80FF0000, 2);
    chk("lh_load", load_data_out, 32'hFFFF80FF);
    retire();
    do_access(1'b1, 1'b0, LHU, 32'h100, 32'h0, 4'h0, 32'h12348765, 1);
    chk("lhu_load", load_data_out, 32'h00008765);
    retire();

    // sh @0x202: store lanes, write held for every stall cycle, load kept
    do_access(1'b0, 1'b1, SH, 32'h202, 32'h1234ABCD, 4'b1100, 32'h99999999, 2);
    chk("sh_wdata", cap_wdata, 32'hABCD0000);
    chk("sh_wmask", {28'h0, cap_wmask}, 32'h0000000C);
    chk("sh_addr", cap_addr, 32'h200);
    chk("sh_write_cycles", 32'(reqs), 32'd3);
    chk("sh_stalls", 32'(stalls), 32'd3);
    chk("sh_load_kept", load_data_out, 32'h00008765);
    chk1("sh_done_write", dmem_write, 1'b0);
    retire();

    // sb @0x301
    do_access(1'b0, 1'b1, SB, 32'h301, 32'h000000A5, 4'b0010, 32'h0, 1);
    chk("sb_wdata", cap_wdata, 32'h0000A500);
    retire();

    // Held in DONE for 3 cycles; a stray response there is ignored
    do_access(1'b1, 1'b0, LW, 32'h400, 32'h0, 4'h0, 32'h11223344, 1);
    reqs   = 0;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_resp  = (i == 1);
      dmem_rdata = 32'hFFFFFFFF;
      #1;
      if (stall_out) stalls++;
      if (dmem_read || dmem_write) reqs++;
      tick();
    end
    dmem_resp = 1'b0;
    chk("done_hold_reqs", 32'(reqs), 32'd0);
    chk("done_hold_stalls", 32'(stalls), 32'd0);
    chk("done_stray_resp", load_data_out, 32'h11223344);
    retire();

    // Reset in WAIT, then a late response lands in IDLE
    drive(1'b1, 1'b0, LW, 32'h500, 32'h0, 4'h0);
    tick();
    #1;
    chk1("wait_read_before_rst", dmem_read, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 4'h0);
    #1;
    chk1("rst_wait_read", dmem_read, 1'b0);
    chk1("rst_wait_stall", stall_out, 1'b0);
    chk("rst_wait_load", load_data_out, 32'h0);
    tick();
    rst        = 1'b0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_resp = 1'b0;
    #1;
    chk("late_resp_load", load_data_out, 32'h0);
    chk1("late_resp_stall", stall_out, 1'b0);
    chk1("late_resp_read", dmem_read, 1'b0);
    tick();

    // Back in IDLE: a new load issues immediately
    do_access(1'b1, 1'b0, LW, 32'h520, 32'h0, 4'h0, 32'h0BADF00D, 1);
    chk("post_rst_stalls", 32'(stalls), 32'd2);
    chk("post_rst_load", load_data_out, 32'h0BADF00D);
    retire();

    // Watchdog: no response, fires on WAIT cycle 8
    drive(1'b1, 1'b0, LW, 32'h600, 32'h0, 4'h0);
    #1;
    chk1("to_req_read", dmem_read, 1'b1);
    tick();
    reqs = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (dmem_read && !timeout_err) reqs++;
      tick();
    end
    chk("to_wait_cycles", 32'(reqs), 32'd8);
    #1;
    chk1("to_pulse", timeout_err, 1'b1);
    chk1("to_read_dropped", dmem_read, 1'b0);
    chk1("to_stall", stall_out, 1'b0);
    chk("to_load_zero", load_data_out, 32'h0);
    tick();
    chk1("to_pulse_end", timeout_err, 1'b0);
    retire();

    // Misaligned word load at 0x101
    drive(1'b1, 1'b0, LW, 32'h101, 32'h0, 4'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
    #1;
    chk1("mis_no_read", dmem_read, 1'b0);
    tick();
    chk1("mis_err", misalign_err, 1'b1);
    chk1("mis_done_read", dmem_read, 1'b0);
    chk1("mis_done_stall", stall_out, 1'b0);
    tick();
    chk1("mis_err_held", misalign_err, 1'b1);
    retire();
    chk1("mis_err_clear", misalign_err, 1'b0);
`else
    do_access(1'b1, 1'b0, LW, 32'h101, 32'h0, 4'h0, 32'h55667788, 1);
    chk("mis_addr", cap_addr, 32'h100);
    chk("mis_req_cycles", 32'(reqs), 32'd2);
    chk1("mis_err_tied", misalign_err, 1'b0);
    chk("mis_load", load_data_out, 32'h55667788);
    retire();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
